// File: rtl/drv_step_pkg.sv
// Shared types and sizing helpers for the multi-channel step pulse generator.
package drv_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } ch_state_e;

    // Timer must hold the largest phase length minus one.
    function automatic int unsigned timer_w(input int unsigned high_cyc,
                                            input int unsigned low_cyc,
                                            input int unsigned dir_setup);
        int unsigned m;
        m = high_cyc;
        if (low_cyc > m)   m = low_cyc;
        if (dir_setup > m) m = dir_setup;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned sel_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/drv_step_ch.sv
// One step-pulse channel: direction setup, then n_steps high/low pulses with pause at pulse boundaries.
// Optional abort input when DRV_ABORT_EN is defined.
module drv_step_ch
    import drv_step_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned HIGH_CYC  = 4,
    parameter int unsigned LOW_CYC   = 4,
    parameter int unsigned DIR_SETUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] n_steps,
    input  logic             dir_in,
    input  logic             en,
`ifdef DRV_ABORT_EN
    input  logic             abort,
`endif
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TMR_W = timer_w(HIGH_CYC, LOW_CYC, DIR_SETUP);
    localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] T_HIGH  = TMR_W'(HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] T_LOW   = TMR_W'(LOW_CYC - 1);

    ch_state_e        state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0] remaining, remaining_nx;
    logic             step_nx, dir_nx, busy_nx, done_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            remaining <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            remaining <= remaining_nx;
            step      <= step_nx;
            dir       <= dir_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        remaining_nx = remaining;
        step_nx      = step;
        dir_nx       = dir;
        done_nx      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load) begin
                    dir_nx       = dir_in;
                    remaining_nx = n_steps;
                    timer_nx     = T_SETUP;
                    state_nx     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer != '0) begin
                    timer_nx = timer - TMR_W'(1);
                end else if (remaining == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else if (en) begin
                    state_nx = ST_HIGH;
                    step_nx  = 1'b1;
                    timer_nx = T_HIGH;
                end
            end
            ST_HIGH: begin
                if (timer != '0) begin
                    timer_nx = timer - TMR_W'(1);
                end else begin
                    step_nx  = 1'b0;
                    state_nx = ST_LOW;
                    timer_nx = T_LOW;
                    if (remaining != '0) remaining_nx = remaining - CNT_W'(1);
                end
            end
            ST_LOW: begin
                // Pause can only take effect here, once the low time has elapsed.
                if (timer != '0) begin
                    timer_nx = timer - TMR_W'(1);
                end else if (remaining == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else if (en) begin
                    state_nx = ST_HIGH;
                    step_nx  = 1'b1;
                    timer_nx = T_HIGH;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                step_nx  = 1'b0;
            end
        endcase

`ifdef DRV_ABORT_EN
        // Abort wins over everything, including a same-cycle load; direction is kept.
        if (abort) begin
            state_nx     = ST_IDLE;
            timer_nx     = '0;
            remaining_nx = '0;
            step_nx      = 1'b0;
            dir_nx       = dir;
            done_nx      = 1'b0;
        end
`endif

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: rtl/drv_step_gen.sv
// Multi-channel stepper pulse generator: load decode, ready mux and per-channel pulse engines.
// Define DRV_ABORT_EN to add the per-channel drv_abort input.
module drv_step_gen
    import drv_step_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned HIGH_CYC  = 4,
    parameter int unsigned LOW_CYC   = 4,
    parameter int unsigned DIR_SETUP = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [sel_w(NUM_CH)-1:0]  ch_sel,
    input  logic [CNT_W-1:0]          n_steps,
    input  logic                      dir_in,
    input  logic [NUM_CH-1:0]         drv_en,
`ifdef DRV_ABORT_EN
    input  logic [NUM_CH-1:0]         drv_abort,
`endif
    output logic [NUM_CH-1:0]         drv_step,
    output logic [NUM_CH-1:0]         drv_dir,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    localparam int unsigned SEL_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0] load;

    // Out-of-range selects leave data_ready low and load nothing.
    always_comb begin
        data_ready = 1'b0;
        load       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                data_ready = ~busy[i];
                load[i]    = data_valid;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        drv_step_ch #(
            .CNT_W     (CNT_W),
            .HIGH_CYC  (HIGH_CYC),
            .LOW_CYC   (LOW_CYC),
            .DIR_SETUP (DIR_SETUP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .n_steps (n_steps),
            .dir_in  (dir_in),
            .en      (drv_en[i]),
`ifdef DRV_ABORT_EN
            .abort   (drv_abort[i]),
`endif
            .step    (drv_step[i]),
            .dir     (drv_dir[i]),
            .busy    (busy[i]),
            .done    (done[i])
        );
    end

endmodule

// File: tb/tb_drv_step_gen.sv
// Bench for drv_step_gen: event-scheduled channel model checked every cycle, plus directed scenarios.
module tb_drv_step_gen;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 16;
    localparam int HIGH_CYC  = 4;
    localparam int LOW_CYC   = 4;
    localparam int DIR_SETUP = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                data_valid = 1'b0;
    logic                data_ready;
    logic [1:0]          ch_sel = '0;
    logic [CNT_W-1:0]    n_steps = '0;
    logic                dir_in = 1'b0;
    logic [NUM_CH-1:0]   drv_en = '1;
`ifdef DRV_ABORT_EN
    logic [NUM_CH-1:0]   drv_abort = '0;
`endif
    logic [NUM_CH-1:0]   drv_step, drv_dir, busy, done;

    int checks = 0;
    int failures = 0;

    // Model: per channel, pulses left, next decision cycle and last rise cycle.
    int  cyc = 0;
    bit  armed = 1'b0;
    bit  m_act  [NUM_CH];
    bit  m_dir  [NUM_CH];
    bit  m_done [NUM_CH];
    int  m_left [NUM_CH];
    int  m_dec  [NUM_CH];
    int  m_rise [NUM_CH];

    always #5 clk = ~clk;

    drv_step_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .HIGH_CYC(HIGH_CYC),
        .LOW_CYC(LOW_CYC), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ch_sel     (ch_sel),
        .n_steps    (n_steps),
        .dir_in     (dir_in),
        .drv_en     (drv_en),
`ifdef DRV_ABORT_EN
        .drv_abort  (drv_abort),
`endif
        .drv_step   (drv_step),
        .drv_dir    (drv_dir),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Advance the model from the cycle just ended (cyc) to the next one.
    task automatic model_step();
        bit ab;
        for (int c = 0; c < NUM_CH; c++) begin
            ab = 1'b0;
`ifdef DRV_ABORT_EN
            ab = drv_abort[c];
`endif
            m_done[c] = 1'b0;
            if (rst) begin
                m_act[c]  = 1'b0;
                m_dir[c]  = 1'b0;
                m_rise[c] = -1000;
            end else if (ab) begin
                m_act[c]  = 1'b0;
                m_rise[c] = -1000;
            end else if (m_act[c]) begin
                if (cyc == m_dec[c]) begin
                    if (m_left[c] == 0) begin
                        m_act[c]  = 1'b0;
                        m_done[c] = 1'b1;
                    end else if (drv_en[c]) begin
                        m_rise[c] = cyc + 1;
                        m_left[c] = m_left[c] - 1;
                        m_dec[c]  = cyc + HIGH_CYC + LOW_CYC;
                    end else begin
                        m_dec[c] = cyc + 1;
                    end
                end
            end else if (data_valid && int'(ch_sel) == c) begin
                m_act[c]  = 1'b1;
                m_dir[c]  = dir_in;
                m_left[c] = int'(n_steps);
                m_dec[c]  = cyc + DIR_SETUP;
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
    endtask

    // One clock: check comb ready, clock edge, advance model, check registered outputs.
    task automatic next();
        logic [NUM_CH-1:0] es, ed, eb, en_d;
        #1;
        if (armed) chk("data_ready", 32'(data_ready), 32'(!m_act[ch_sel]));
        @(posedge clk);
        model_step();
        #1;
        if (armed) begin
            for (int c = 0; c < NUM_CH; c++) begin
                es[c]   = (cyc >= m_rise[c]) && (cyc < m_rise[c] + HIGH_CYC);
                ed[c]   = m_dir[c];
                eb[c]   = m_act[c];
                en_d[c] = m_done[c];
            end
            chk("drv_step", 32'(drv_step), 32'(es));
            chk("drv_dir",  32'(drv_dir),  32'(ed));
            chk("busy",     32'(busy),     32'(eb));
            chk("done",     32'(done),     32'(en_d));
        end
    endtask

    task automatic set_load(input int c, input int n, input bit d);
        data_valid = 1'b1;
        ch_sel     = 2'(c);
        n_steps    = CNT_W'(n);
        dir_in     = d;
    endtask

    int rises, highs, dones, done_at, run;
    int rises3;
    bit prev, prev3;

    initial begin
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        chk("rst_step", 32'(drv_step), 32'h0);
        chk("rst_dir",  32'(drv_dir),  32'h0);
        chk("rst_busy", 32'(busy),     32'h0);
        chk("rst_done", 32'(done),     32'h0);
        next();

        // 1: ch0 three pulses, dir=1
        set_load(0, 3, 1'b1);
        next();
        data_valid = 1'b0;
        chk("t1_dir", 32'(drv_dir[0]), 32'h1);
        chk("t1_busy", 32'(busy[0]), 32'h1);
        rises = 0; highs = 0; dones = 0; done_at = -1; prev = 1'b0;
        for (int o = 1; o <= 40; o++) begin
            if (o == 2) chk("t1_pre_rise", 32'(drv_step[0]), 32'h0);
            if (o == 3) chk("t1_first_rise", 32'(drv_step[0]), 32'h1);
            if (drv_step[0] && !prev) rises++;
            if (drv_step[0]) highs++;
            if (done[0]) begin dones++; done_at = o; end
            prev = drv_step[0];
            next();
        end
        chk("t1_rises", 32'(rises), 32'd3);
        chk("t1_highs", 32'(highs), 32'd12);
        chk("t1_dones", 32'(dones), 32'd1);
        chk("t1_done_at", 32'(done_at), 32'd27);
        chk("t1_busy_end", 32'(busy[0]), 32'h0);

        // 2: ch1 zero steps
        set_load(1, 0, 1'b1);
        next();
        data_valid = 1'b0;
        rises = 0; dones = 0; done_at = -1;
        for (int o = 1; o <= 10; o++) begin
            if (drv_step[1]) rises++;
            if (done[1]) begin dones++; done_at = o; end
            next();
        end
        chk("t2_steps", 32'(rises), 32'd0);
        chk("t2_done_at", 32'(done_at), 32'd3);
        chk("t2_dones", 32'(dones), 32'd1);
        chk("t2_dir", 32'(drv_dir[1]), 32'h1);

        // 3: ch2 five pulses, enable dropped during the 2nd high
        set_load(2, 5, 1'b1);
        next();
        data_valid = 1'b0;
        rises = 0; dones = 0; done_at = -1; run = 0; prev = 1'b0;
        for (int o = 1; o <= 60; o++) begin
            if (drv_step[2] && !prev) rises++;
            if (drv_step[2]) run++;
            if (!drv_step[2] && prev) begin
                chk("t3_width", 32'(run), 32'd4);
                run = 0;
            end
            if (done[2]) begin dones++; done_at = o; end
            prev = drv_step[2];
            drv_en[2] = !(o >= 12 && o <= 21);
            next();
        end
        drv_en = '1;
        chk("t3_rises", 32'(rises), 32'd5);
        chk("t3_done_at", 32'(done_at), 32'd47);
        chk("t3_dones", 32'(dones), 32'd1);

        // 4: load to busy ch0 refused, ch3 load in parallel
        set_load(0, 4, 1'b1);
        next();
        data_valid = 1'b0;
        rises = 0; rises3 = 0; prev = 1'b0; prev3 = 1'b0;
        for (int o = 1; o <= 45; o++) begin
            if (drv_step[0] && !prev) rises++;
            if (drv_step[3] && !prev3) rises3++;
            prev = drv_step[0];
            prev3 = drv_step[3];
            data_valid = 1'b0;
            if (o == 5) begin
                set_load(0, 1, 1'b0);
                #1 chk("t4_ready_busy", 32'(data_ready), 32'h0);
            end
            if (o == 6) begin
                set_load(3, 2, 1'b1);
                #1 chk("t4_ready_idle", 32'(data_ready), 32'h1);
            end
            next();
        end
        data_valid = 1'b0;
        chk("t4_rises0", 32'(rises), 32'd4);
        chk("t4_rises3", 32'(rises3), 32'd2);
        chk("t4_dir0", 32'(drv_dir[0]), 32'h1);

        // 5: reset during a high phase
        set_load(0, 3, 1'b1);
        next();
        data_valid = 1'b0;
        next();
        next();
        next();
        chk("t5_high", 32'(drv_step[0]), 32'h1);
        rst = 1'b1;
        next();
        rst = 1'b0;
        chk("t5_step_cut", 32'(drv_step[0]), 32'h0);
        chk("t5_busy", 32'(busy[0]), 32'h0);
        dones = 0;
        for (int o = 1; o <= 12; o++) begin
            if (done[0] || drv_step[0]) dones++;
            next();
        end
        chk("t5_quiet", 32'(dones), 32'd0);
        set_load(0, 1, 1'b1);
        next();
        data_valid = 1'b0;
        rises = 0; done_at = -1; prev = 1'b0;
        for (int o = 1; o <= 15; o++) begin
            if (drv_step[0] && !prev) rises++;
            if (done[0]) done_at = o;
            prev = drv_step[0];
            next();
        end
        chk("t5_reload_rises", 32'(rises), 32'd1);
        chk("t5_reload_done", 32'(done_at), 32'd11);

`ifdef DRV_ABORT_EN
        // 6: abort ch1 mid-low with a same-cycle load
        set_load(1, 3, 1'b1);
        next();
        data_valid = 1'b0;
        for (int o = 1; o <= 8; o++) begin
            if (o == 8) begin
                drv_abort = 4'b0010;
                set_load(1, 2, 1'b0);
            end
            next();
        end
        drv_abort = '0;
        data_valid = 1'b0;
        chk("t6_busy", 32'(busy[1]), 32'h0);
        chk("t6_step", 32'(drv_step[1]), 32'h0);
        chk("t6_dir_held", 32'(drv_dir[1]), 32'h1);
        dones = 0;
        for (int o = 1; o <= 20; o++) begin
            if (done[1] || drv_step[1]) dones++;
            next();
        end
        chk("t6_quiet", 32'(dones), 32'd0);
        drv_abort = 4'b0100;
        set_load(2, 2, 1'b1);
        next();
        drv_abort = '0;
        data_valid = 1'b0;
        chk("t6_idle_abort_load", 32'(busy[2]), 32'h0);
        next();
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            ch_sel     = 2'($urandom_range(0, NUM_CH - 1));
            n_steps    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(6, 12))
                                                     : CNT_W'($urandom_range(0, 4));
            dir_in     = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) drv_en[c] = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 499) == 0);
`ifdef DRV_ABORT_EN
            for (int c = 0; c < NUM_CH; c++) drv_abort[c] = ($urandom_range(0, 299) == 0);
`endif
            next();
        end
        data_valid = 1'b0;
        rst = 1'b0;
        drv_en = '1;
`ifdef DRV_ABORT_EN
        drv_abort = '0;
`endif
        for (int i = 0; i < 150; i++) next();
        chk("drain_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
